// File: rtl/sb_rx_deserializer_pkg.sv
// ----------------------------------------------------------------------------
// sb_rx_pkg
//   Shared definitions for the sideband receive deserializer.
//   - sb_rx_state_e : receiver FSM states (IDLE, SHIFT, GAP)
//   - SB_PKT_W      : sideband packet width in bits
//   - SB_GAP_CYCLES : minimum idle cycles between packets
// ----------------------------------------------------------------------------
package sb_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } sb_rx_state_e;

    localparam int unsigned SB_PKT_W      = 64;
    localparam int unsigned SB_GAP_CYCLES = 32;

endpackage : sb_rx_pkg

// File: rtl/sb_rx_deserializer.sv
// ----------------------------------------------------------------------------
// sb_rx_deserializer
//   Samples the serial sideband line MSB-first, one bit per i_pll_clk cycle
//   while i_rxsb_valid is high, and presents each completed DATA_W-bit packet
//   as a parallel word. A packet cut short by i_rxsb_valid dropping is
//   discarded and flagged.
//
//   Optional feature macro: SB_RX_GAP_CHECK_EN
//     defined   : after each packet the GAP state counts idle cycles; a new
//                 packet starting before GAP_CYCLES idle cycles raises
//                 o_gap_err (the packet is still received).
//     undefined : a completed packet returns straight to IDLE; o_gap_err = 0.
//
//   Ports
//     i_pll_clk     in   sideband PLL clock, rising edge
//     i_rst         in   synchronous active-high reset
//     i_rxsb_data   in   serial data, MSB first
//     i_rxsb_valid  in   serial data qualifier
//     o_data_out    out  last completed packet (MSB = first bit received)
//     o_data_valid  out  one-cycle pulse, o_data_out is new
//     o_frame_err   out  one-cycle pulse, packet truncated
//     o_gap_err     out  one-cycle pulse, inter-packet gap too short
//     o_busy        out  high while the FSM is not in IDLE
// ----------------------------------------------------------------------------
module sb_rx_deserializer
    import sb_rx_pkg::*;
#(
    parameter int unsigned DATA_W     = SB_PKT_W,
    parameter int unsigned GAP_CYCLES = SB_GAP_CYCLES
) (
    input  logic              i_pll_clk,
    input  logic              i_rst,
    input  logic              i_rxsb_data,
    input  logic              i_rxsb_valid,
    output logic [DATA_W-1:0] o_data_out,
    output logic              o_data_valid,
    output logic              o_frame_err,
    output logic              o_gap_err,
    output logic              o_busy
);

    // Counter value reached when the final bit of a packet is sampled.
    localparam logic [6:0] LAST_BIT = 7'(DATA_W);

    sb_rx_state_e      state;
    logic [DATA_W-1:0] shift;
    logic [6:0]        bit_cnt;

`ifdef SB_RX_GAP_CHECK_EN
    localparam logic [5:0] GAP_LAST = 6'(GAP_CYCLES);
    logic [5:0]        gap_cnt;
`endif

    always_ff @(posedge i_pll_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            shift        <= '0;
            bit_cnt      <= '0;
            o_data_out   <= '0;
            o_data_valid <= 1'b0;
            o_frame_err  <= 1'b0;
            o_busy       <= 1'b0;
`ifdef SB_RX_GAP_CHECK_EN
            gap_cnt      <= '0;
            o_gap_err    <= 1'b0;
`endif
        end else begin
            o_data_valid <= 1'b0;
            o_frame_err  <= 1'b0;
`ifdef SB_RX_GAP_CHECK_EN
            o_gap_err    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (i_rxsb_valid) begin
                        shift   <= {{(DATA_W-1){1'b0}}, i_rxsb_data};
                        bit_cnt <= 7'd1;
                        state   <= SHIFT;
                        o_busy  <= 1'b1;
                    end else begin
                        o_busy  <= 1'b0;
                    end
                end

                SHIFT: begin
                    if (i_rxsb_valid) begin
                        shift <= {shift[DATA_W-2:0], i_rxsb_data};
                        if (bit_cnt == LAST_BIT - 7'd1) begin
                            // Final bit: publish the word including this bit.
                            o_data_out   <= {shift[DATA_W-2:0], i_rxsb_data};
                            o_data_valid <= 1'b1;
                            bit_cnt      <= '0;
`ifdef SB_RX_GAP_CHECK_EN
                            state        <= GAP;
                            gap_cnt      <= '0;
                            o_busy       <= 1'b1;
`else
                            state        <= IDLE;
                            o_busy       <= 1'b0;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 7'd1;
                        end
                    end else begin
                        // Truncated packet: drop the partial word.
                        shift       <= '0;
                        bit_cnt     <= '0;
                        o_frame_err <= 1'b1;
                        state       <= IDLE;
                        o_busy      <= 1'b0;
                    end
                end

`ifdef SB_RX_GAP_CHECK_EN
                GAP: begin
                    if (i_rxsb_valid) begin
                        // Early start: flag it but still accept the bit.
                        o_gap_err <= 1'b1;
                        shift     <= {{(DATA_W-1){1'b0}}, i_rxsb_data};
                        bit_cnt   <= 7'd1;
                        gap_cnt   <= '0;
                        state     <= SHIFT;
                    end else if (gap_cnt == GAP_LAST - 6'd1) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                        o_busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 6'd1;
                    end
                end
`endif

                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

`ifndef SB_RX_GAP_CHECK_EN
    assign o_gap_err = 1'b0;
`endif

endmodule : sb_rx_deserializer
